conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter IMG_W, default 8, input feature-map width in pixels (legal range >= 3).
REQ-002 Parameter IMG_H, default 8, input feature-map height in pixels (legal range >= 3).
REQ-003 Parameter AW, default $clog2(IMG_W*IMG_H), pixel and result address width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to convolve the whole map.
REQ-007 abort  input  1  synchronous cancel of the current job.
REQ-008 w_in  input  9  binary 3x3 kernel, bit k = tap k (row-major), 1 = subtract.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle pulse when the job completes.
REQ-011 rd_en  output  1  pixel-memory read strobe.
REQ-012 rd_addr  output  AW  pixel address = row*IMG_W + col.
REQ-013 rd_data  input  12  Q4.8 pixel, valid exactly 1 cycle after rd_en.
REQ-014 conv_clr  output  1  one-cycle clear to the conv engine.
REQ-015 en_conv  output  1  conv engine tap-enable, one pixel per cycle.
REQ-016 conv_data  output  12  pixel presented to the engine.
REQ-017 conv_w  output  9  latched kernel presented to the engine.
REQ-018 conv_finish  input  1  engine result-ready flag.
REQ-019 conv_out  input  16  engine result, Q8.8.
REQ-020 res_valid, res_ready  output/input  1  result valid/ready handshake.
REQ-021 res_data  output  16  Q8.8 result; res_addr  output  AW  = orow*(IMG_W-2)+ocol.

Function
REQ-022 FSM states SHALL be IDLE, CLR, FETCH, WAIT, OUT, DONE.
REQ-023 IDLE: start=1 SHALL latch w_in into conv_w, zero orow/ocol, set busy, go to CLR next cycle.
REQ-024 start while busy SHALL be ignored; w_in changes after acceptance SHALL NOT affect conv_w.
REQ-025 CLR: conv_clr=1 for exactly one cycle, then FETCH.
REQ-026 FETCH: 9 consecutive rd_en cycles, tap k=0..8 address (orow+k/3)*IMG_W + ocol + k%3.
REQ-027 en_conv SHALL be high exactly the 9 cycles after each rd_en cycle, conv_data = rd_data registered through.
REQ-028 After the 9th en_conv cycle, FSM SHALL enter WAIT with en_conv=0, rd_en=0.
REQ-029 WAIT: on conv_finish=1, capture conv_out into res_data, set res_addr, go to OUT.
REQ-030 OUT: res_valid=1, res_data/res_addr stable until res_valid&&res_ready.
REQ-031 On handshake: ocol increments; at ocol=IMG_W-3 wrap to 0 and increment orow; go to CLR.
REQ-032 Handshake on the last window (orow=IMG_H-3, ocol=IMG_W-3) SHALL go to DONE instead.
REQ-033 DONE: done=1 one cycle, busy cleared same cycle, return to IDLE.
REQ-034 Total results per job SHALL be (IMG_W-2)*(IMG_H-2), res_addr strictly ascending from 0.
REQ-035 Window cost SHALL be 1 (CLR) + 10 (FETCH/en) + engine latency + 1 min (OUT) cycles.
REQ-036 abort in any non-IDLE state SHALL return to IDLE next cycle with conv_clr=1 that cycle, busy=0, no done, no res_valid.
REQ-037 abort has priority over start, conv_finish and res_ready in the same cycle.
REQ-038 conv_finish outside WAIT SHALL be ignored.

Reset
REQ-039 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, rd_en=0, en_conv=0, conv_clr=0, res_valid=0.
REQ-040 rst SHALL clear rd_addr, conv_data, conv_w, res_data, res_addr, orow, ocol to 0.
REQ-041 Reset mid-job SHALL discard the job; first cycle after release accepts a new start.

Verification
REQ-042 IMG_W=IMG_H=4, all pixels 0x100, w_in=0 -> 4 results 0x0900, res_addr 0,1,2,3, then one done pulse.
REQ-043 Same map, w_in=9'h1FF -> 4 results 0xF700; conv_w=9'h1FF throughout.
REQ-044 res_ready held low 5 cycles in OUT -> res_valid, res_data, res_addr unchanged, no new rd_en.
REQ-045 Pixel p=addr (0x000..0x00F), window (1,1) -> rd_addr sequence 5,6,7,9,10,11,13,14,15.
REQ-046 rst asserted mid-FETCH -> all outputs 0 immediately; new start completes a full correct job.
REQ-047 start during busy, abort during WAIT -> start ignored; abort gives IDLE next cycle, conv_clr pulse, no done.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: walks a 3x3 binary-kernel convolution over an IMG_W x IMG_H map, one result per window
module conv_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [8:0]    w_in,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [11:0]   rd_data,
  output logic          conv_clr,
  output logic          en_conv,
  output logic [11:0]   conv_data,
  output logic [8:0]    conv_w,
  input  logic          conv_finish,
  input  logic [15:0]   conv_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic [AW-1:0] res_addr
);
  typedef enum logic [2:0] {IDLE, CLR, FETCH, WAIT, OUT, DONE} state_t;
  localparam logic [AW-1:0] W_A  = AW'(IMG_W);
  localparam logic [AW-1:0] OW_A = AW'(IMG_W-2);
  localparam logic [AW-1:0] LC   = AW'(IMG_W-3);
  localparam logic [AW-1:0] LR   = AW'(IMG_H-3);
  localparam logic [AW-1:0] ONE  = AW'(1);
  state_t        state;
  logic [AW-1:0] orow, ocol;
  logic [3:0]    k;
  logic [1:0]    tc;
  logic          last;
  assign last = (ocol == LC) && (orow == LR);
  // memory data is already registered; it is only exposed to the engine in its tap-enable cycle
  assign conv_data = en_conv ? rd_data : '0;
  // scheduler FSM with registered outputs; tc tracks the kernel column of the tap being read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      conv_clr  <= 1'b0;
      en_conv   <= 1'b0;
      conv_w    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
      orow      <= '0;
      ocol      <= '0;
      k         <= '0;
      tc        <= '0;
    end else begin
      conv_clr <= 1'b0;
      done     <= 1'b0;
      en_conv  <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        conv_clr  <= 1'b1;
        busy      <= 1'b0;
        rd_en     <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state    <= CLR;
            conv_w   <= w_in;
            orow     <= '0;
            ocol     <= '0;
            busy     <= 1'b1;
            conv_clr <= 1'b1;
          end
          CLR: begin
            state   <= FETCH;
            rd_en   <= 1'b1;
            rd_addr <= orow * W_A + ocol;
            k       <= 4'd1;
            tc      <= 2'd0;
          end
          FETCH: begin
            en_conv <= rd_en;
            if (k == 4'd10) state <= WAIT;
            else if (k == 4'd9) begin
              rd_en <= 1'b0;
              k     <= 4'd10;
            end else begin
              rd_addr <= rd_addr + (tc == 2'd2 ? OW_A : ONE);
              tc      <= tc == 2'd2 ? 2'd0 : tc + 2'd1;
              k       <= k + 4'd1;
            end
          end
          WAIT: if (conv_finish) begin
            state     <= OUT;
            res_data  <= conv_out;
            res_addr  <= orow * OW_A + ocol;
            res_valid <= 1'b1;
          end
          OUT: if (res_ready) begin
            res_valid <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= CLR;
              conv_clr <= 1'b1;
              ocol     <= ocol == LC ? '0 : ocol + ONE;
              orow     <= ocol == LC ? orow + ONE : orow;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed checks of conv_sched on a 4x4 map with a behavioural memory and engine
module tb_conv_sched;
  localparam int W = 4, H = 4, AW = 4;
  logic clk = 0, rst = 1, start = 0, abort = 0, res_ready = 1;
  logic [8:0] w_in = 0;
  logic busy, done, rd_en, conv_clr, en_conv, res_valid;
  logic [AW-1:0] rd_addr, res_addr;
  logic [11:0] rd_data = 0, conv_data;
  logic [8:0] conv_w;
  logic conv_finish = 0;
  logic [15:0] conv_out, res_data, acc = 0, ext;
  logic [3:0] cnt = 0;
  logic [11:0] mem [16];
  logic [AW-1:0] addr_q [$];
  int en_cnt = 0;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  conv_sched #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .w_in(w_in),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_clr(conv_clr), .en_conv(en_conv), .conv_data(conv_data), .conv_w(conv_w),
    .conv_finish(conv_finish), .conv_out(conv_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_addr(res_addr)
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  assign ext = {{4{conv_data[11]}}, conv_data};
  assign conv_out = acc;
  always @(posedge clk) begin
    if (rst || conv_clr) begin
      acc <= 0; cnt <= 0; conv_finish <= 0;
    end else begin
      if (en_conv) begin
        acc <= conv_w[cnt] ? acc - ext : acc + ext;
        cnt <= cnt + 1;
      end
      conv_finish <= (cnt == 9);
    end
  end

  always @(negedge clk) begin
    if (rd_en) addr_q.push_back(rd_addr);
    if (en_conv) en_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_job(input logic [8:0] w);
    @(negedge clk); start = 1; w_in = w;
    @(negedge clk); start = 0; w_in = ~w;
    nvec++;
    if ({busy, conv_clr, conv_w} !== {2'b11, w}) begin
      nerr++; $display("FAIL start_accept got busy=%b clr=%b w=%h want 1 1 %h", busy, conv_clr, conv_w, w);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int j = 0; j < 100 && !ok; j++) begin
      @(negedge clk);
      ok = res_valid;
    end
  endtask

  task automatic collect(input logic [63:0] ex, input logic [8:0] w, input bit stall, input string tag);
    bit ok;
    bit bad;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      nvec++;
      if (!ok) begin
        nerr++; $display("FAIL %s result %0d timeout waiting res_valid", tag, i);
        return;
      end
      e = ex[16*(3-i) +: 16];
      nvec++;
      if ({res_data, res_addr, conv_w} !== {e, AW'(i), w}) begin
        nerr++; $display("FAIL %s result %0d got data=%h addr=%0d w=%h want %h %0d %h", tag, i, res_data, res_addr, conv_w, e, i, w);
      end
      if (stall && i == 0) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          nvec++;
          if ({res_valid, res_data, res_addr, rd_en} !== {1'b1, e, AW'(0), 1'b0}) begin
            nerr++; $display("FAIL %s stall %0d got v=%b d=%h a=%0d rd=%b want 1 %h 0 0", tag, j, res_valid, res_data, res_addr, rd_en, e);
          end
        end
        res_ready = 1;
      end
    end
    ok = 0;
    for (int j = 0; j < 20 && !ok; j++) begin
      @(negedge clk);
      ok = done;
    end
    nvec++;
    if (!ok || busy !== 1'b0) begin
      nerr++; $display("FAIL %s done got seen=%b busy=%b want 1 0", tag, ok, busy);
    end
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) bad = 1;
    end
    nvec++;
    if (bad) begin
      nerr++; $display("FAIL %s post_done got extra done/busy/valid want quiet", tag);
    end
  endtask

  task automatic test_reset;
    nvec++;
    if ({busy, done, rd_en, en_conv, conv_clr, res_valid} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, rd_en, en_conv, conv_clr, res_valid});
    end
    nvec++;
    if ({rd_addr, conv_data, conv_w, res_data, res_addr} !== '0) begin
      nerr++; $display("FAIL reset_data got addr=%h cd=%h w=%h rd=%h ra=%h want 0", rd_addr, conv_data, conv_w, res_data, res_addr);
    end
  endtask

  task automatic test_uniform_pos;
    start_job(9'h000);
    collect({4{16'h0900}}, 9'h000, 0, "uniform_pos");
  endtask

  task automatic test_uniform_neg;
    start_job(9'h1FF);
    collect({4{16'hF700}}, 9'h1FF, 0, "uniform_neg");
  endtask

  task automatic test_stall;
    res_ready = 0;
    start_job(9'h000);
    collect({4{16'h0900}}, 9'h000, 1, "stall");
  endtask

  task automatic test_start_abort;
    bit seen, hit, bad;
    start_job(9'h000);
    @(negedge clk);
    start = 1; w_in = 9'h1FF;
    @(negedge clk);
    start = 0;
    nvec++;
    if ({busy, conv_w} !== {1'b1, 9'h000}) begin
      nerr++; $display("FAIL start_busy got busy=%b w=%h want 1 000", busy, conv_w);
    end
    seen = 0; hit = 0;
    for (int j = 0; j < 40 && !hit; j++) begin
      @(negedge clk);
      if (en_conv) seen = 1;
      else if (seen) hit = 1;
    end
    nvec++;
    if (!hit || {rd_en, en_conv, res_valid, busy} !== 4'b0001) begin
      nerr++; $display("FAIL wait_state got hit=%b rd=%b en=%b v=%b busy=%b want 1 0 0 0 1", hit, rd_en, en_conv, res_valid, busy);
    end
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    nvec++;
    if ({busy, conv_clr, res_valid, done} !== 4'b0100) begin
      nerr++; $display("FAIL abort got busy=%b clr=%b v=%b done=%b want 0 1 0 0", busy, conv_clr, res_valid, done);
    end
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (busy || done || res_valid || conv_clr || rd_en) bad = 1;
    end
    nvec++;
    if (bad) begin
      nerr++; $display("FAIL abort_quiet got activity after abort want idle");
    end
    start_job(9'h000);
    collect({4{16'h0900}}, 9'h000, 0, "after_abort");
  endtask

  task automatic test_reset_mid;
    bit hit;
    start_job(9'h0A5);
    hit = 0;
    for (int j = 0; j < 10 && !hit; j++) begin
      @(negedge clk);
      hit = rd_en;
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (!hit || rd_en !== 1'b1) begin
      nerr++; $display("FAIL mid_fetch got rd_en=%b want 1", rd_en);
    end
    rst = 1;
    #1;
    nvec++;
    if ({busy, done, rd_en, en_conv, conv_clr, res_valid, rd_addr, conv_data, conv_w, res_data, res_addr} !== '0) begin
      nerr++; $display("FAIL reset_mid got busy=%b rd=%b en=%b a=%h w=%h want all 0", busy, rd_en, en_conv, rd_addr, conv_w);
    end
    @(negedge clk);
    rst = 0; start = 1; w_in = 9'h000;
    @(negedge clk);
    start = 0;
    nvec++;
    if ({busy, conv_clr} !== 2'b11) begin
      nerr++; $display("FAIL restart got busy=%b clr=%b want 1 1", busy, conv_clr);
    end
    collect({4{16'h0900}}, 9'h000, 0, "reset_mid");
  endtask

  task automatic test_addr_map;
    logic [AW-1:0] exp_a [9] = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i < 16; i++) mem[i] = 12'(i);
    addr_q.delete();
    en_cnt = 0;
    start_job(9'h000);
    collect({16'h002D, 16'h0036, 16'h0051, 16'h005A}, 9'h000, 0, "addr_map");
    nvec++;
    if (addr_q.size() != 36 || en_cnt != 36) begin
      nerr++; $display("FAIL addr_count got reads=%0d en=%0d want 36 36", addr_q.size(), en_cnt);
    end else begin
      for (int j = 0; j < 9; j++) begin
        nvec++;
        if (addr_q[27+j] !== exp_a[j]) begin
          nerr++; $display("FAIL win11_addr tap %0d got %0d want %0d", j, addr_q[27+j], exp_a[j]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h100;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 0;
    test_uniform_pos;
    test_uniform_neg;
    test_stall;
    test_start_abort;
    test_reset_mid;
    test_addr_map;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
